pipelined_cla_addsub: RTL and testbench



---
 rtl/pipelined_cla_addsub.sv | 129 ++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit add/subtract: one 16-bit carry-lookahead slice resolved per stage,
// with a global-stall valid/ready handshake and carry, signed-overflow and zero flags.
module pipelined_cla_addsub #(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICE = WIDTH / 16;

    // Handshake: a beat moves on valid & ready at either side; when advance is low the
    // whole pipeline (data, valid bits, outputs) holds, so bubbles never collapse.
    logic advance;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Returns {carry into bit 15, slice carry-out, 16-bit sum}.
    function automatic logic [17:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c0);
        logic [15:0] p, g, c;
        logic [3:0]  gp, gg;
        logic [4:0]  gc;
        int          bi;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < 4; j++) begin
            bi    = 4 * j;
            gp[j] = p[bi] & p[bi+1] & p[bi+2] & p[bi+3];
            gg[j] = g[bi+3] | (p[bi+3] & g[bi+2]) | (p[bi+3] & p[bi+2] & g[bi+1])
                  | (p[bi+3] & p[bi+2] & p[bi+1] & g[bi]);
        end
        gc[0] = c0;
        gc[1] = gg[0] | (gp[0] & c0);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c0);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
        for (int j = 0; j < 4; j++) begin
            bi      = 4 * j;
            c[bi]   = gc[j];
            c[bi+1] = g[bi] | (p[bi] & gc[j]);
            c[bi+2] = g[bi+1] | (p[bi+1] & g[bi]) | (p[bi+1] & p[bi] & gc[j]);
            c[bi+3] = g[bi+2] | (p[bi+2] & g[bi+1]) | (p[bi+2] & p[bi+1] & g[bi])
                    | (p[bi+2] & p[bi+1] & p[bi] & gc[j]);
        end
        return {c[15], gc[4], p ^ c};
    endfunction

    // Index k is the input of stage k; index NSLICE is the final register.
    // px carries operand A with finished slices overwritten by their sum bits.
    logic [WIDTH-1:0] px [NSLICE+1];
    logic [WIDTH-1:0] pb [NSLICE];
    logic             pc [NSLICE+1];
    logic             pv [NSLICE+1];
    logic             r_ovf;
    logic             r_zero;

    assign px[0] = a;
    assign pb[0] = sub ? ~b : b;
    assign pc[0] = sub ? ~cin : cin;
    assign pv[0] = in_valid;

    for (genvar k = 0; k < NSLICE; k++) begin : g_stage
        localparam int LO = 16 * k;
        logic [17:0]      res;
        logic [WIDTH-1:0] nx;

        always_comb begin
            res          = cla16(px[k][LO +: 16], pb[k][LO +: 16], pc[k]);
            nx           = px[k];
            nx[LO +: 16] = res[15:0];
        end

        // Data only loads on valid beats so idle cycles leave the last result in place.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv[k+1] <= 1'b0;
                pc[k+1] <= 1'b0;
                px[k+1] <= '0;
            end else if (advance) begin
                pv[k+1] <= pv[k];
                if (pv[k]) begin
                    pc[k+1] <= res[16];
                    px[k+1] <= nx;
                end
            end
        end

        if (k < NSLICE - 1) begin : g_fwd
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pb[k+1] <= '0;
                end else if (advance && pv[k]) begin
                    pb[k+1] <= pb[k];
                end
            end
        end else begin : g_flags
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (advance && pv[k]) begin
                    r_ovf  <= res[17] ^ res[16];
                    r_zero <= (nx == '0);
                end
            end
        end
    end

    assign out_valid = pv[NSLICE];
    assign s         = px[NSLICE];
    assign cout      = pc[NSLICE];
    assign ovf       = r_ovf;
    assign zero      = REG_OUT ? r_zero : (px[NSLICE] == '0);

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed arithmetic/reset/backpressure steps and a random
// soak against an arithmetic reference model through an expected-result queue.
module tb_pipelined_cla_addsub;
    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 16;
    localparam int RW     = WIDTH + 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    pipelined_cla_addsub #(.WIDTH(WIDTH), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              checks;
    int              failures;
    int              retired;
    int              sent;
    logic            accepted;
    logic            hold_prev;
    logic [RW:0]     held;
    logic [RW-1:0]   exp_q[$];

    // Reference: plain wide arithmetic; result packed as {zero, ovf, cout, s}.
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic msub, input logic mcin);
        logic [WIDTH+1:0] ua, ub, ur, sa, sb, sr;
        logic [WIDTH-1:0] sum;
        logic             co, ov;
        ua = {2'b00, ma};
        ub = {2'b00, mb};
        sa = {{2{ma[WIDTH-1]}}, ma};
        sb = {{2{mb[WIDTH-1]}}, mb};
        if (!msub) begin
            ur = ua + ub + {{(WIDTH+1){1'b0}}, mcin};
            sr = sa + sb + {{(WIDTH+1){1'b0}}, mcin};
            co = ur[WIDTH];
        end else begin
            ur = ua - ub - {{(WIDTH+1){1'b0}}, mcin};
            sr = sa - sb - {{(WIDTH+1){1'b0}}, mcin};
            co = !ur[WIDTH+1];
        end
        sum = ur[WIDTH-1:0];
        ov  = !((sr[WIDTH+1:WIDTH-1] == 3'b000) || (sr[WIDTH+1:WIDTH-1] == 3'b111));
        return {(sum == '0), ov, co, sum};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operands();
        a   = WIDTH'({$urandom, $urandom});
        b   = WIDTH'({$urandom, $urandom});
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    // One clock of scoreboard accounting; inputs must already be driven.
    task automatic acct();
        logic [RW-1:0] got;
        @(negedge clk);
        chk("in_ready_rule", in_ready, (!out_valid || out_ready));
        if (hold_prev) chk("hold_stable", {zero, ovf, cout, s, out_valid}, held);
        got = {zero, ovf, cout, s};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_without_beat", 1'b1, 1'b0 ^ out_valid ^ 1'b1);
            else begin
                chk("result", got, exp_q.pop_front());
                retired++;
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(model(a, b, sub, cin));
        hold_prev = out_valid && !out_ready;
        held      = {zero, ovf, cout, s, out_valid};
        tick();
    endtask

    task automatic send_check(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                              input logic tsub, input logic tcin, input logic [WIDTH-1:0] es,
                              input logic ecout, input logic eovf, input logic ezero);
        a = ta; b = tb; sub = tsub; cin = tcin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        rand_operands();
        for (int i = 0; i < NSLICE - 1; i++) begin
            chk({tag, "_early_valid"}, out_valid, 1'b0);
            tick();
        end
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ecout);
        chk({tag, "_ovf"}, ovf, eovf);
        chk({tag, "_zero"}, zero, ezero);
        tick();
    endtask

    initial begin
        checks = 0; failures = 0; retired = 0; sent = 0;
        accepted = 1'b0; hold_prev = 1'b0; held = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_s", s, '0);
        chk("rst_flags", {cout, ovf, zero}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // Directed arithmetic
        send_check("add_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        send_check("wrap", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        send_check("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        send_check("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        send_check("add_ovf", 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
        send_check("sub_borrow", 32'h00000003, 32'h00000002, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

        // Reset mid-stream with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_operands();
        tick();
        rand_operands();
        tick();
        in_valid = 1'b0;
        chk("mid_rst_pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_s", s, '0);
        chk("mid_rst_flags", {cout, ovf, zero}, 3'b000);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_spurious", out_valid, 1'b0);
            chk("mid_rst_s_quiet", s, '0);
        end

        // Backpressure: six beats, consumer stalls on cycles 3..5
        exp_q.delete();
        hold_prev = 1'b0; retired = 0; sent = 0;
        for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
            in_valid = (sent < 6);
            rand_operands();
            out_ready = !(c >= 3 && c <= 5);
            if (c == 4) begin
                @(negedge clk);
                chk("bp_in_ready_stall", in_ready, 1'b0);
            end
            acct();
            if (accepted) sent++;
        end
        in_valid = 1'b0;
        chk("bp_retired", retired, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Random soak
        hold_prev = 1'b0; retired = 0; sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_operands();
            out_ready = ($urandom_range(0, 3) != 0);
            acct();
            if (accepted) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) acct();
        chk("soak_sent", sent, 10000);
        chk("soak_retired", retired, 10000);
        chk("soak_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
